// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode plus ID/EX pipeline register.
// Accepts one instruction per valid/ready handshake, decodes it, selects the
// ALU operands from register-file data, PC and immediates, and registers the
// result for the execute stage with one cycle of latency.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   InValid/InReady             fetch-side handshake (InReady combinational)
//   Instr, PC                   instruction word and its address
//   Rs1Addr, Rs2Addr            register-file read addresses (combinational)
//   RsData1, RsData2            same-cycle register-file read data
//   Flush                       drop the held and incoming instruction
//   OutValid/OutReady           execute-side handshake
//   Operand1, Operand2          ALU operands
//   Operation                   ALU operation code (MSB set for branch/JALR/LUI)
//   StoreData, LinkValue        rs2 for stores, PC+4 for jumps
//   TargetPC                    branch/JAL target
//   Rd + control flags          destination and RegWrite/MemRead/MemWrite/
//                               IsBranch/IsJal/Illegal
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int OP_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            InValid,
  output logic            InReady,
  input  logic [31:0]     Instr,
  input  logic [XLEN-1:0] PC,
  output logic [4:0]      Rs1Addr,
  output logic [4:0]      Rs2Addr,
  input  logic [XLEN-1:0] RsData1,
  input  logic [XLEN-1:0] RsData2,
  input  logic            Flush,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Operand1,
  output logic [XLEN-1:0] Operand2,
  output logic [OP_W-1:0] Operation,
  output logic [XLEN-1:0] StoreData,
  output logic [XLEN-1:0] LinkValue,
  output logic [XLEN-1:0] TargetPC,
  output logic [4:0]      Rd,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IsBranch,
  output logic            IsJal,
  output logic            Illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00000;
  localparam logic [OP_W-1:0] OP_LUI  = 5'b11000;
  localparam logic [OP_W-1:0] OP_JALR = 5'b11001;

  // funct3 to the low three ALU code bits: only SLTU and OR are permuted.
  function automatic logic [2:0] alu_sel(input logic [2:0] f3);
    case (f3)
      3'b011:  alu_sel = 3'b110;
      3'b110:  alu_sel = 3'b011;
      default: alu_sel = f3;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            f7_zero;
  logic            f7_alt;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [XLEN-1:0] d_op1, d_op2, d_target;
  logic [OP_W-1:0] d_oper;
  logic            d_wr_raw, d_rd, d_wm, d_br, d_jal, d_ill;
  logic            load;

  assign opcode  = Instr[6:0];
  assign f3      = Instr[14:12];
  assign f7      = Instr[31:25];
  assign f7_zero = (f7 == 7'b0000000);
  assign f7_alt  = (f7 == 7'b0100000);
  assign Rs1Addr = Instr[19:15];
  assign Rs2Addr = Instr[24:20];

  assign imm_i = {{(XLEN-12){Instr[31]}}, Instr[31:20]};
  assign imm_s = {{(XLEN-12){Instr[31]}}, Instr[31:25], Instr[11:7]};
  assign imm_b = {{(XLEN-13){Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
  assign imm_u = {{(XLEN-32){Instr[31]}}, Instr[31:12], 12'h000};

  assign InReady = ~OutValid | OutReady;
  assign load    = InValid & InReady & ~Flush;

  // Instruction decode and operand selection; illegal encodings keep Operation=ADD.
  always_comb begin
    d_op1    = '0;
    d_op2    = '0;
    d_target = '0;
    d_oper   = OP_ADD;
    d_wr_raw = 1'b0;
    d_rd     = 1'b0;
    d_wm     = 1'b0;
    d_br     = 1'b0;
    d_jal    = 1'b0;
    d_ill    = 1'b0;
    case (opcode)
      OPC_OP: begin
        d_op1    = RsData1;
        d_op2    = RsData2;
        d_wr_raw = 1'b1;
        // The alternate funct7 only exists for SUB and SRA.
        if (f7_zero || (f7_alt && (f3 == 3'b000 || f3 == 3'b101))) begin
          d_oper = {1'b0, f7_alt, alu_sel(f3)};
        end else begin
          d_ill = 1'b1;
        end
      end
      OPC_OPIMM: begin
        d_op1    = RsData1;
        d_wr_raw = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // Shift-immediates: shamt zero-extended, funct7 checked as for OP.
          d_op2 = {{(XLEN-5){1'b0}}, Instr[24:20]};
          if (f7_zero || (f7_alt && f3 == 3'b101)) begin
            d_oper = {1'b0, f7_alt, alu_sel(f3)};
          end else begin
            d_ill = 1'b1;
          end
        end else begin
          d_op2  = imm_i;
          d_oper = {2'b00, alu_sel(f3)};
        end
      end
      OPC_LOAD: begin
        d_op1    = RsData1;
        d_op2    = imm_i;
        d_rd     = 1'b1;
        d_wr_raw = 1'b1;
      end
      OPC_STORE: begin
        d_op1 = RsData1;
        d_op2 = imm_s;
        d_wm  = 1'b1;
      end
      OPC_BRANCH: begin
        d_op1    = RsData1;
        d_op2    = RsData2;
        d_target = PC + imm_b;
        if (f3[2:1] == 2'b01) begin
          d_ill = 1'b1;
        end else begin
          d_oper = {2'b10, f3};
          d_br   = 1'b1;
        end
      end
      OPC_JALR: begin
        d_op1    = RsData1;
        d_op2    = imm_i;
        d_oper   = OP_JALR;
        d_wr_raw = 1'b1;
      end
      OPC_JAL: begin
        d_op1    = PC;
        d_op2    = {{(XLEN-3){1'b0}}, 3'b100};
        d_target = PC + imm_j;
        d_jal    = 1'b1;
        d_wr_raw = 1'b1;
      end
      OPC_LUI: begin
        d_op2    = imm_u;
        d_oper   = OP_LUI;
        d_wr_raw = 1'b1;
      end
      OPC_AUIPC: begin
        d_op1    = PC;
        d_op2    = imm_u;
        d_wr_raw = 1'b1;
      end
      default: begin
        d_ill = 1'b1;
      end
    endcase
  end

  // Pipeline register: flush beats load, load beats drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OutValid  <= 1'b0;
      Operand1  <= '0;
      Operand2  <= '0;
      Operation <= OP_ADD;
      StoreData <= '0;
      LinkValue <= '0;
      TargetPC  <= '0;
      Rd        <= 5'd0;
      RegWrite  <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      IsBranch  <= 1'b0;
      IsJal     <= 1'b0;
      Illegal   <= 1'b0;
    end else begin
      if (Flush) begin
        OutValid <= 1'b0;
      end else if (load) begin
        OutValid <= 1'b1;
      end else if (OutReady) begin
        OutValid <= 1'b0;
      end else begin
        OutValid <= OutValid;
      end
      if (load) begin
        Operand1  <= d_op1;
        Operand2  <= d_op2;
        Operation <= d_oper;
        StoreData <= RsData2;
        LinkValue <= PC + {{(XLEN-3){1'b0}}, 3'b100};
        TargetPC  <= d_target;
        Rd        <= Instr[11:7];
        // Illegal encodings and writes to x0 never update the register file.
        RegWrite  <= d_wr_raw & ~d_ill & (Instr[11:7] != 5'd0);
        MemRead   <= d_rd & ~d_ill;
        MemWrite  <= d_wm & ~d_ill;
        IsBranch  <= d_br;
        IsJal     <= d_jal;
        Illegal   <= d_ill;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        InValid, InReady, Flush, OutValid, OutReady;
  logic [31:0] Instr, PC, RsData1, RsData2;
  logic [4:0]  Rs1Addr, Rs2Addr, Rd;
  logic [31:0] Operand1, Operand2, StoreData, LinkValue, TargetPC;
  logic [4:0]  Operation;
  logic        RegWrite, MemRead, MemWrite, IsBranch, IsJal, Illegal;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.XLEN(32), .OP_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
    .Instr(Instr), .PC(PC), .Rs1Addr(Rs1Addr), .Rs2Addr(Rs2Addr),
    .RsData1(RsData1), .RsData2(RsData2), .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady), .Operand1(Operand1),
    .Operand2(Operand2), .Operation(Operation), .StoreData(StoreData),
    .LinkValue(LinkValue), .TargetPC(TargetPC), .Rd(Rd),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .IsBranch(IsBranch), .IsJal(IsJal), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    Instr = ins; PC = pc; RsData1 = r1; RsData2 = r2;
  endtask

  initial begin
    rst_n = 1'b0; InValid = 1'b0; Flush = 1'b0; OutReady = 1'b1;
    drive(32'h0000_0013, 32'h0, 32'h0, 32'h0);
    #2;
    chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
    chk("rst_operation", {27'd0, Operation}, 32'd0);
    chk("rst_operand2", Operand2, 32'd0);
    chk("rst_inready", {31'd0, InReady}, 32'd1);
    cycle();
    rst_n = 1'b1;

    // ADDI x5,x1,-1
    InValid = 1'b1;
    drive(32'hFFF0_8293, 32'h0, 32'h0000_0010, 32'h0000_0022);
    cycle();
    chk("addi_valid", {31'd0, OutValid}, 32'd1);
    chk("addi_op1", Operand1, 32'h0000_0010);
    chk("addi_op2", Operand2, 32'hFFFF_FFFF);
    chk("addi_oper", {27'd0, Operation}, 32'h00);
    chk("addi_rd", {27'd0, Rd}, 32'd5);
    chk("addi_rw", {31'd0, RegWrite}, 32'd1);

    // SRA x3,x4,x6
    drive(32'h4062_51B3, 32'h0, 32'h8000_0000, 32'h0000_0004);
    #1;
    chk("sra_rs1addr", {27'd0, Rs1Addr}, 32'd4);
    chk("sra_rs2addr", {27'd0, Rs2Addr}, 32'd6);
    cycle();
    chk("sra_oper", {27'd0, Operation}, 32'h0D);
    chk("sra_op1", Operand1, 32'h8000_0000);
    chk("sra_op2", Operand2, 32'h0000_0004);
    chk("sra_rd", {27'd0, Rd}, 32'd3);

    // SUB x3,x4,x6
    drive(32'h4062_01B3, 32'h0, 32'h1, 32'h2);
    cycle();
    chk("sub_oper", {27'd0, Operation}, 32'h08);
    chk("sub_illegal", {31'd0, Illegal}, 32'd0);

    // AND with funct7=0100000 is illegal
    drive(32'h4062_71B3, 32'h0, 32'h1, 32'h2);
    cycle();
    chk("andalt_illegal", {31'd0, Illegal}, 32'd1);
    chk("andalt_rw", {31'd0, RegWrite}, 32'd0);
    chk("andalt_oper", {27'd0, Operation}, 32'h00);

    // BGEU x1,x2,-8 at PC=0x100
    drive(32'hFE20_FCE3, 32'h0000_0100, 32'h5, 32'h6);
    cycle();
    chk("bgeu_oper", {27'd0, Operation}, 32'h17);
    chk("bgeu_target", TargetPC, 32'h0000_00F8);
    chk("bgeu_isbranch", {31'd0, IsBranch}, 32'd1);
    chk("bgeu_rw", {31'd0, RegWrite}, 32'd0);

    // JALR x1,8(x2) at PC=0x200
    drive(32'h0081_00E7, 32'h0000_0200, 32'h0000_1000, 32'h0);
    cycle();
    chk("jalr_oper", {27'd0, Operation}, 32'h19);
    chk("jalr_link", LinkValue, 32'h0000_0204);
    chk("jalr_op1", Operand1, 32'h0000_1000);
    chk("jalr_op2", Operand2, 32'h0000_0008);
    chk("jalr_rw", {31'd0, RegWrite}, 32'd1);

    // LUI x7,0xABCDE
    drive(32'hABCD_E3B7, 32'h0, 32'h1234_5678, 32'h0);
    cycle();
    chk("lui_op2", Operand2, 32'hABCD_E000);
    chk("lui_op1", Operand1, 32'h0000_0000);
    chk("lui_oper", {27'd0, Operation}, 32'h18);
    chk("lui_rd", {27'd0, Rd}, 32'd7);

    // ADD x0,x1,x2: write to x0 suppressed
    drive(32'h0020_8033, 32'h0, 32'h1, 32'h2);
    cycle();
    chk("addx0_rw", {31'd0, RegWrite}, 32'd0);
    chk("addx0_illegal", {31'd0, Illegal}, 32'd0);

    // LW x9,12(x1)
    drive(32'h00C0_A483, 32'h0, 32'h0000_0400, 32'h0);
    cycle();
    chk("lw_memread", {31'd0, MemRead}, 32'd1);
    chk("lw_op2", Operand2, 32'h0000_000C);
    chk("lw_rw", {31'd0, RegWrite}, 32'd1);

    // SW x2,4(x1)
    drive(32'h0020_A223, 32'h0, 32'h0000_0300, 32'hDEAD_BEEF);
    cycle();
    chk("sw_memwrite", {31'd0, MemWrite}, 32'd1);
    chk("sw_op2", Operand2, 32'h0000_0004);
    chk("sw_storedata", StoreData, 32'hDEAD_BEEF);
    chk("sw_rw", {31'd0, RegWrite}, 32'd0);

    // Unknown opcode
    drive(32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2);
    cycle();
    chk("badop_illegal", {31'd0, Illegal}, 32'd1);
    chk("badop_rw", {31'd0, RegWrite}, 32'd0);
    chk("badop_memread", {31'd0, MemRead}, 32'd0);
    chk("badop_memwrite", {31'd0, MemWrite}, 32'd0);
    chk("badop_oper", {27'd0, Operation}, 32'h00);

    // Stall: ADDI loaded, then OutReady low for 3 cycles while LUI is offered
    drive(32'hFFF0_8293, 32'h0, 32'h0000_0010, 32'h0);
    cycle();
    OutReady = 1'b0;
    drive(32'hABCD_E3B7, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_valid", {31'd0, OutValid}, 32'd1);
      chk("stall_op2", Operand2, 32'hFFFF_FFFF);
      chk("stall_op1", Operand1, 32'h0000_0010);
      chk("stall_inready", {31'd0, InReady}, 32'd0);
    end
    OutReady = 1'b1;
    #1;
    chk("release_inready", {31'd0, InReady}, 32'd1);
    cycle();
    chk("passthru_oper", {27'd0, Operation}, 32'h18);
    chk("passthru_valid", {31'd0, OutValid}, 32'd1);

    // Drain with no new instruction
    InValid = 1'b0;
    cycle();
    chk("drain_valid", {31'd0, OutValid}, 32'd0);

    // Flush overrides an incoming load
    InValid = 1'b1;
    drive(32'h0020_8033, 32'h0, 32'h1, 32'h2);
    cycle();
    chk("preflush_valid", {31'd0, OutValid}, 32'd1);
    Flush = 1'b1;
    drive(32'hFFF0_8293, 32'h0, 32'h0000_0010, 32'h0);
    #1;
    chk("flush_inready", {31'd0, InReady}, 32'd1);
    cycle();
    chk("flush_valid", {31'd0, OutValid}, 32'd0);
    Flush = 1'b0;

    // Async reset in the middle of a stall
    cycle();
    chk("prereset_valid", {31'd0, OutValid}, 32'd1);
    OutReady = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", {31'd0, OutValid}, 32'd0);
    chk("areset_op1", Operand1, 32'd0);
    chk("areset_op2", Operand2, 32'd0);
    chk("areset_rd", {27'd0, Rd}, 32'd0);
    chk("areset_rw", {31'd0, RegWrite}, 32'd0);
    chk("areset_link", LinkValue, 32'd0);
    rst_n = 1'b1;
    InValid = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
